// File: rtl/issue_scheduler.sv
// Dual-slot in-order issue scheduler feeding a Branch and a Memory pipeline.
// Optional ISSUE_SCHED_PERF_EN adds dual-issue and stall performance counters.
module issue_scheduler #(
    parameter int QDEPTH = 4,
    parameter int TAG_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            dec_valid,
    output logic                  dec_ready,
    input  logic [1:0][1:0]       dec_class,
    input  logic [1:0][4:0]       dec_rd,
    input  logic [1:0][4:0]       dec_rs1,
    input  logic [1:0][4:0]       dec_rs2,
    input  logic [1:0][TAG_W-1:0] dec_tag,
    output logic                  br_valid,
    output logic [TAG_W-1:0]      br_tag,
    input  logic                  br_ready,
    output logic                  mem_valid,
    output logic [TAG_W-1:0]      mem_tag,
    input  logic                  mem_ready,
    input  logic                  ex_load_valid,
    input  logic [4:0]            ex_load_rd,
`ifdef ISSUE_SCHED_PERF_EN
    output logic [31:0]           perf_dual_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    input  logic                  flush
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_BR  = 2'b01;

    logic [1:0]       q_cls [QDEPTH];
    logic [4:0]       q_rd  [QDEPTH];
    logic [4:0]       q_rs1 [QDEPTH];
    logic [4:0]       q_rs2 [QDEPTH];
    logic [TAG_W-1:0] q_tag [QDEPTH];

    logic [AW-1:0] head, tail, head1, wr1;
    logic [CW-1:0] count, free;

    logic       stop, il0, il1, dep, conflict;
    logic       e0_live, e1_cand, e1_live, e0_mem, e0_rdy, e1_rdy;
    logic       deq0, deq1;
    logic [1:0] acc, enq_n, deq_n;
    logic       br_fire, mem_fire;

    function automatic logic interlocked(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic lv, input logic [4:0] lrd);
        return lv && (lrd != 5'd0) && ((rs1 == lrd) || (rs2 == lrd));
    endfunction

    always_comb begin
        stop     = rst | flush;
        head1    = head + AW'(1);
        free     = CW'(QDEPTH) - count;
        il0      = interlocked(q_rs1[head], q_rs2[head], ex_load_valid, ex_load_rd);
        il1      = interlocked(q_rs1[head1], q_rs2[head1], ex_load_valid, ex_load_rd);
        dep      = (q_rd[head] != 5'd0) &&
                   ((q_rs1[head1] == q_rd[head]) || (q_rs2[head1] == q_rd[head]) ||
                    (q_rd[head1] == q_rd[head]));
        // Only two non-ALU classes bound to the same pipe can collide; an ALU takes whichever is free.
        conflict = (q_cls[head] != CLS_ALU) && (q_cls[head1] != CLS_ALU) &&
                   (q_cls[head][1] == q_cls[head1][1]);

        e0_live  = !stop && (count != '0) && !il0;
        e1_cand  = e0_live && (count >= CW'(2)) && !il1 && !dep && !conflict;

        if (q_cls[head] == CLS_ALU)
            e0_mem = e1_cand && (q_cls[head1] == CLS_BR);
        else
            e0_mem = q_cls[head][1];

        e0_rdy  = e0_mem ? mem_ready : br_ready;
        e1_rdy  = e0_mem ? br_ready  : mem_ready;
        e1_live = e1_cand && e0_rdy;

        br_valid  = (e0_live && !e0_mem) || (e1_live && e0_mem);
        mem_valid = (e0_live && e0_mem)  || (e1_live && !e0_mem);
        br_tag    = '0;
        mem_tag   = '0;
        if (e0_live && !e0_mem) br_tag  = q_tag[head];
        if (e1_live && e0_mem)  br_tag  = q_tag[head1];
        if (e0_live && e0_mem)  mem_tag = q_tag[head];
        if (e1_live && !e0_mem) mem_tag = q_tag[head1];

        deq0  = e0_live && e0_rdy;
        deq1  = e1_live && e1_rdy;
        deq_n = {1'b0, deq0} + {1'b0, deq1};

        dec_ready = !stop && (free >= CW'(2));
        acc       = dec_valid & {2{dec_ready}};
        enq_n     = {1'b0, acc[0]} + {1'b0, acc[1]};
        wr1       = tail + AW'(acc[0]);

        br_fire  = br_valid && br_ready;
        mem_fire = mem_valid && mem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(deq_n);
            tail  <= tail + AW'(enq_n);
            count <= count + CW'(enq_n) - CW'(deq_n);
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (acc[0]) begin
            q_cls[tail] <= dec_class[0];
            q_rd[tail]  <= dec_rd[0];
            q_rs1[tail] <= dec_rs1[0];
            q_rs2[tail] <= dec_rs2[0];
            q_tag[tail] <= dec_tag[0];
        end
        if (acc[1]) begin
            q_cls[wr1] <= dec_class[1];
            q_rd[wr1]  <= dec_rd[1];
            q_rs1[wr1] <= dec_rs1[1];
            q_rs2[wr1] <= dec_rs2[1];
            q_tag[wr1] <= dec_tag[1];
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (br_fire && mem_fire && (perf_dual_cnt != '1))
                perf_dual_cnt <= perf_dual_cnt + 32'd1;
            if ((count != '0) && !br_fire && !mem_fire && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 Parameter QDEPTH, default 4, instruction-queue entries; SHALL be a power of 2 and at least 4.
REQ-002 Parameter TAG_W, default 32, width of the opaque per-instruction payload passed to the pipelines.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 dec_valid  input  2  per-slot decode valid; slot 0 is the older instruction.
REQ-006 dec_ready  output  1  both decode slots accepted this cycle.
REQ-007 dec_class  input  2x2  per slot: 00 ALU, 01 BR, 10 LD, 11 ST.
REQ-008 dec_rd, dec_rs1, dec_rs2  input  2x5 each  per-slot register indices.
REQ-009 dec_tag  input  2xTAG_W  per-slot payload.
REQ-010 br_valid, br_tag  output  1, TAG_W  issue to Branch pipeline.
REQ-011 br_ready  input  1  Branch pipeline Issue stage not stalled.
REQ-012 mem_valid, mem_tag  output  1, TAG_W  issue to Memory pipeline.
REQ-013 mem_ready  input  1  Memory pipeline Issue stage not stalled.
REQ-014 ex_load_valid, ex_load_rd  input  1, 5  load currently in Ex stage and its destination.
REQ-015 flush  input  1  branch correction; discards every queued instruction.

Function
REQ-016 dec_ready SHALL be 1 when free entries >= 2 and flush = 0; accepted valid slots SHALL be enqueued in order, slot 0 first; invalid slots SHALL NOT occupy entries.
REQ-017 An instruction accepted in cycle N SHALL be presentable no earlier than cycle N+1; br_*/mem_* SHALL be combinational from queue head state and the ex_load/ready inputs.
REQ-018 Head E0 SHALL be steered: LD/ST -> Memory; BR -> Branch; ALU -> Branch, except ALU -> Memory when E1 is BR and E1 is dual-issuable.
REQ-019 E1 SHALL be dual-issued only when: its target pipe is unused by E0 (ALU takes the remaining pipe), E1 rs1/rs2 != E0 rd, E1 rd != E0 rd (comparisons ignored for register 0), and E1 is not interlocked.
REQ-020 Interlock: an entry with rs1 or rs2 equal to ex_load_rd (non-zero) while ex_load_valid = 1 SHALL NOT be presented; an interlocked E0 also blocks E1.
REQ-021 An entry dequeues only on valid & ready of its pipe; E1 SHALL dequeue only in a cycle where E0 dequeues; if E0's pipe is not ready, E1 valid SHALL be 0.
REQ-022 Pointers SHALL wrap modulo QDEPTH; occupancy count width clog2(QDEPTH)+1; simultaneous enqueue of 2 and dequeue of 2 SHALL leave occupancy unchanged.
REQ-023 Empty queue: br_valid = mem_valid = 0; one entry: only E0 considered.
REQ-024 flush = 1: queue emptied at next edge, br_valid = mem_valid = 0 and dec_ready = 0 in the flush cycle; flush wins over same-cycle enqueue and dequeue.

Reset
REQ-025 While rst = 1: queue empty, pointers and count 0, br_valid = mem_valid = 0, dec_ready = 0, tags 0.
REQ-026 The cycle after rst deasserts, dec_ready SHALL be 1.
REQ-027 rst asserted mid-operation SHALL discard all entries without issuing them.

Configuration
REQ-028 Macro ISSUE_SCHED_PERF_EN: when defined, add outputs perf_dual_cnt (32) and perf_stall_cnt (32).
REQ-029 perf_dual_cnt SHALL count cycles both pipes fire; perf_stall_cnt SHALL count cycles a non-empty queue issues nothing. Both saturate at all-ones and clear on rst.
REQ-030 When the macro is not defined, no counter ports or logic SHALL exist; all other behaviour is identical.

Verification
REQ-031 Slot0 LD x5, slot1 ADD x6,x1,x2, both ready -> cycle N+1 mem_valid = br_valid = 1, both dequeue.
REQ-032 Slot0 ADD x5,x1,x2, slot1 SUB x7,x5,x3 -> N+1 only br_valid (ADD); N+2 br_valid (SUB).
REQ-033 Queue holds LD, LD -> one mem issue per cycle, br_valid = 0 throughout.
REQ-034 ex_load_valid = 1, ex_load_rd = 4, head ADD x8,x4,x1 -> br_valid = 0 that cycle; issues the cycle ex_load_valid drops.
REQ-035 Queue at QDEPTH-1 entries -> dec_ready = 0; flush asserted with dec_valid = 11 -> next cycle queue empty, nothing enqueued.
REQ-036 Pointer wrap: stream 3*QDEPTH instructions with random br_ready/mem_ready -> every tag issued exactly once, in order.
